rr_stream_mux: RTL and testbench

//   Parametrised N-channel streaming multiplexer with valid/ready handshakes.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/rr_stream_mux_arbiter.sv | 53 +++++
 rtl/rr_stream_mux.sv | 69 ++++++
 tb/tb_rr_stream_mux.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the streaming mux and its arbiter.
package mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Channel-select width; a single channel still needs a 1-bit index.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Round-robin / fixed-priority arbiter; owns the round-robin pointer register.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  MODE   = MODE_RR,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic             found;
  logic [SEL_W-1:0] probe;

  // Search upward from the pointer (or from 0 in fixed mode), wrapping at NUM_CH-1.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    probe     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      probe = (MODE == MODE_RR) ? SEL_W'((int'(ptr_reg) + k) % NUM_CH) : SEL_W'(k);
      if (!found && req[probe]) begin
        found     = 1'b1;
        grant_idx = probe;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
      assign grant[gi] = found && (int'(grant_idx) == gi);
    end
  endgenerate

  always_comb begin
    ptr_next = ptr_reg;
    if (MODE == MODE_RR && advance) begin
      ptr_next = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with arbitration and a registered output stage.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int  WIDTH  = 8,
  parameter int  NUM_CH = 4,
  parameter int  MODE   = MODE_RR,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_channel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  out_data_reg;
  logic [SEL_W-1:0]  out_channel_reg;
  logic              out_valid_reg;
  logic              load_en;
  logic              transfer;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;

  // The register is free when empty or being drained on this same edge.
  assign load_en  = !out_valid_reg || out_ready;
  assign transfer = load_en && (|in_valid) && !rst;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE)
  ) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready[gi] = load_en && grant[gi] && !rst;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_channel_reg <= '0;
    end else if (transfer) begin
      out_valid_reg   <= 1'b1;
      out_data_reg    <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_channel_reg <= grant_idx;
    end else if (out_ready) begin
      out_valid_reg   <= 1'b0;
    end
  end

  assign out_data    = out_data_reg;
  assign out_channel = out_channel_reg;
  assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench: round-robin and fixed-priority instances driven in lockstep against a reference model.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0] ir0, ir1;
  logic [7:0] od0, od1;
  logic [1:0] oc0, oc1;
  logic       ov0, ov1;

  always #5 clk = ~clk;

  rr_stream_mux #(.WIDTH(8), .NUM_CH(4), .MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
    .out_data(od0), .out_channel(oc0), .out_valid(ov0), .out_ready(out_ready)
  );

  rr_stream_mux #(.WIDTH(8), .NUM_CH(4), .MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
    .out_data(od1), .out_channel(oc1), .out_valid(ov1), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state per mode: index 0 = round-robin, 1 = fixed priority.
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  int         m_ch    [2];
  int         m_ptr   [2];
  logic [3:0] cap_ir0, cap_ir1;

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic [3:0] exp_ir;
    logic       exp_ov;
    int         exp_ch;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0; m_data[m] = 8'h00; m_ch[m] = 0; m_ptr[m] = 0;
    end
  endtask

  // Rotate the request vector to start at the pointer and take the first set bit.
  function automatic int pick(input int m, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m == 0) ? (m_ptr[m] + k) % 4 : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic tick();
    int         g    [2];
    logic       load [2];
    logic [3:0] er   [2];
    @(negedge clk);
    cap_ir0 = ir0;
    cap_ir1 = ir1;
    for (int m = 0; m < 2; m++) begin
      g[m]    = pick(m, in_valid);
      load[m] = !m_valid[m] || out_ready;
      er[m]   = (!rst && load[m] && g[m] >= 0) ? 4'(1 << g[m]) : 4'b0000;
    end
    chk("in_ready_rr", {28'd0, cap_ir0}, {28'd0, er[0]});
    chk("in_ready_fp", {28'd0, cap_ir1}, {28'd0, er[1]});
    @(posedge clk);
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 1'b0; m_data[m] = 8'h00; m_ch[m] = 0; m_ptr[m] = 0;
      end else if (load[m] && g[m] >= 0) begin
        m_valid[m] = 1'b1;
        m_data[m]  = in_data[g[m]*8 +: 8];
        m_ch[m]    = g[m];
        if (m == 0) m_ptr[m] = (g[m] + 1) % 4;
      end else if (out_ready) begin
        m_valid[m] = 1'b0;
      end
    end
    chk("out_valid_rr", {31'd0, ov0}, {31'd0, m_valid[0]});
    chk("out_data_rr",  {24'd0, od0}, {24'd0, m_data[0]});
    chk("out_chan_rr",  {30'd0, oc0}, 32'(m_ch[0]));
    chk("out_valid_fp", {31'd0, ov1}, {31'd0, m_valid[1]});
    chk("out_data_fp",  {24'd0, od1}, {24'd0, m_data[1]});
    chk("out_chan_fp",  {30'd0, oc1}, 32'(m_ch[1]));
    $display("cyc %0d rst=%b v=%b rdy=%b | rr ir=%b ov=%b ch=%0d d=%h | fp ir=%b ov=%b ch=%0d d=%h",
             cyc, rst, in_valid, out_ready, cap_ir0, ov0, oc0, od0, cap_ir1, ov1, oc1, od1);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, ov0}, 32'd0);
    chk("reset_out_data",  {24'd0, od0}, 32'd0);
    chk("reset_in_ready",  {28'd0, ir0}, 32'd0);
    rst = 1'b0;

    // Round-robin cycle, drain, then sparse wrap from pointer 2.
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1};
    tbl[7] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 3};
    tbl[8] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1};
    tbl[9] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 3};
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].v;
      out_ready = tbl[i].rdy;
      tick();
      chk("tbl_in_ready",  {28'd0, cap_ir0}, {28'd0, tbl[i].exp_ir});
      chk("tbl_out_valid", {31'd0, ov0}, {31'd0, tbl[i].exp_ov});
      chk("tbl_out_chan",  {30'd0, oc0}, 32'(tbl[i].exp_ch));
    end

    // Backpressure: ch2 beat 0xA5 held while the consumer stalls.
    set_data(8'h10, 8'h11, 8'hA5, 8'h13);
    in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data",     {24'd0, od0}, 32'h0000_00A5);
      chk("stall_chan",     {30'd0, oc0}, 32'd2);
      chk("stall_valid",    {31'd0, ov0}, 32'd1);
      chk("stall_in_ready", {28'd0, cap_ir0}, 32'd0);
    end
    in_valid = 4'b0000; out_ready = 1'b1;
    tick();
    chk("stall_drained", {31'd0, ov0}, 32'd0);

    // Drain and load on the same edge.
    set_data(8'h3C, 8'h77, 8'h00, 8'h00);
    in_valid = 4'b0010;
    tick();
    in_valid = 4'b0001;
    tick();
    chk("dl_data",  {24'd0, od0}, 32'h0000_003C);
    chk("dl_valid", {31'd0, ov0}, 32'd1);
    chk("dl_chan",  {30'd0, oc0}, 32'd0);

    // Fixed priority: ch1 starves ch3 until it drops.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fp_chan",     {30'd0, oc1}, 32'd1);
      chk("fp_in_ready", {28'd0, cap_ir1}, 32'd2);
    end
    in_valid = 4'b1000;
    tick();
    chk("fp_ch3_after_drop", {30'd0, oc1}, 32'd3);

    // Asynchronous reset mid-stream with a beat held.
    in_valid = 4'b1111; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, ov0}, 32'd0);
    chk("async_out_data",  {24'd0, od0}, 32'd0);
    chk("async_out_chan",  {30'd0, oc0}, 32'd0);
    chk("async_in_ready",  {28'd0, ir0}, 32'd0);
    chk("async_fp_valid",  {31'd0, ov1}, 32'd0);
    model_reset();
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("post_reset_grant", {28'd0, cap_ir0}, 32'd1);
    chk("post_reset_chan",  {30'd0, oc0}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
